// File: rtl/crono_pkg.sv
// Shared stopwatch definitions: seven-segment patterns, default digit moduli
// and the segment decode helper used by every digit stage.
package crono_pkg;

   // Segment patterns ordered {A,B,C,D,E,F,G}, active-high.
   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Default moduli for the tens-of-seconds and tens-of-minutes digits.
   localparam int SEC_TENS_MODULUS = 6;
   localparam int MIN_TENS_MODULUS = 6;

   // Action taken by a digit stage in a given cycle, in priority order.
   typedef enum logic [1:0] {
      ACT_HOLD = 2'd0,
      ACT_CLR  = 2'd1,
      ACT_LOAD = 2'd2,
      ACT_STEP = 2'd3
   } digit_act_e;

   // Decimal digit to segment pattern; anything above 9 blanks the display.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] seg;
      case (d)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronises an asynchronous ripple carry and turns each rising edge into a
// single-cycle step. Edges are only honoured once the synchronised line has
// been seen low after reset, so a carry held high across reset release is
// never mistaken for a fresh edge.
module sync_edge_det
   import crono_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic step_o
);

   // Synchroniser chain, and a matching fill marker that tells us when the
   // chain output reflects a real sample rather than its reset value.
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] fill_q;
   logic                   hist_q;
   logic                   armed_q;
   logic                   armed_d;
   logic                   cin_s;

   assign cin_s = sync_q[SYNC_STAGES-1];

   // Arm on the first genuine low sample of the synchronised carry.
   always_comb begin
      armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~cin_s);
   end

   // Synchroniser, fill marker, edge history and arming flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q  <= '0;
         fill_q  <= '0;
         hist_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], async_i};
         fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         hist_q  <= cin_s;
         armed_q <= armed_d;
      end
   end

   assign step_o = cin_s & ~hist_q & armed_q;

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("sync_edge_det: SYNC_STAGES must be at least 2");
   end

endmodule

// File: rtl/ten_min.sv
// Tens-of-minutes digit of the stopwatch: counts synchronised ripple-carry
// edges up or down modulo MODULUS, with clear, preset and pause, and drives
// its seven-segment display plus carry/borrow pulses for the hours stage.
module ten_min
   import crono_pkg::*;
#(
   parameter int MODULUS     = MIN_TENS_MODULUS,
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       CARRY_IN,
   input  logic       UP,
   input  logic       RUN,
   input  logic       CLR,
   input  logic       LOAD,
   input  logic [3:0] LD_VAL,
   output logic [3:0] DIGIT,
   output logic       SEG_A,
   output logic       SEG_B,
   output logic       SEG_C,
   output logic       SEG_D,
   output logic       SEG_E,
   output logic       SEG_F,
   output logic       SEG_G,
   output logic       CARRY_OUT,
   output logic       BORROW_OUT,
   output logic       ZERO
);

   localparam logic [3:0] MAX_VAL = 4'(MODULUS - 1);

   logic       step;
   digit_act_e act;
   logic [3:0] ld_clamped;
   logic [3:0] digit_q;
   logic [3:0] digit_d;
   logic       carry_q;
   logic       carry_d;
   logic       borrow_q;
   logic       borrow_d;

   sync_edge_det #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge_det (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .async_i(CARRY_IN),
      .step_o (step)
   );

   // Out-of-range presets saturate to the top count.
   assign ld_clamped = (LD_VAL > MAX_VAL) ? MAX_VAL : LD_VAL;

   // Pick this cycle's action; a step coinciding with CLR/LOAD is dropped.
   always_comb begin
      act = ACT_HOLD;
      if (CLR) begin
         act = ACT_CLR;
      end else if (LOAD) begin
         act = ACT_LOAD;
      end else if (step && RUN) begin
         act = ACT_STEP;
      end
   end

   // Next digit value and wrap pulses; only a wrapping step raises a pulse.
   always_comb begin
      digit_d  = digit_q;
      carry_d  = 1'b0;
      borrow_d = 1'b0;
      case (act)
         ACT_CLR:  digit_d = 4'd0;
         ACT_LOAD: digit_d = ld_clamped;
         ACT_STEP: begin
            if (UP) begin
               if (digit_q >= MAX_VAL) begin
                  digit_d = 4'd0;
                  carry_d = 1'b1;
               end else begin
                  digit_d = digit_q + 4'd1;
               end
            end else begin
               if (digit_q == 4'd0) begin
                  digit_d  = MAX_VAL;
                  borrow_d = 1'b1;
               end else begin
                  digit_d = digit_q - 4'd1;
               end
            end
         end
         default: digit_d = digit_q;
      endcase
   end

   // Digit register and registered wrap pulses.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         digit_q  <= 4'd0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         digit_q  <= digit_d;
         carry_q  <= carry_d;
         borrow_q <= borrow_d;
      end
   end

   assign DIGIT      = digit_q;
   assign CARRY_OUT  = carry_q;
   assign BORROW_OUT = borrow_q;
   assign ZERO       = (digit_q == 4'd0);
   assign {SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G} = seg_decode(digit_q);

   if (MODULUS < 2 || MODULUS > 10) begin : g_bad_mod
      $error("ten_min: MODULUS must be in 2..10");
   end

endmodule

// File: tb/tb_ten_min.sv
// Directed bench for the tens-of-minutes stopwatch digit.
module tb_ten_min;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       CARRY_IN = 1'b0;
   logic       UP = 1'b1;
   logic       RUN = 1'b1;
   logic       CLR = 1'b0;
   logic       LOAD = 1'b0;
   logic [3:0] LD_VAL = 4'd0;
   logic [3:0] DIGIT;
   logic       SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G;
   logic       CARRY_OUT, BORROW_OUT, ZERO;

   int n_vec = 0;
   int n_err = 0;

   // Hand-written {A..G} patterns for digits 0..9.
   logic [6:0] seg_exp [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011};

   typedef struct {
      logic       up;
      logic       run;
      logic       pulse;
      logic       clr;
      logic       load;
      logic [3:0] ld;
      logic [3:0] exp_d;
      logic       exp_c;
      logic       exp_b;
   } vec_t;

   vec_t vecs [14];

   ten_min dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .CARRY_IN  (CARRY_IN),
      .UP        (UP),
      .RUN       (RUN),
      .CLR       (CLR),
      .LOAD      (LOAD),
      .LD_VAL    (LD_VAL),
      .DIGIT     (DIGIT),
      .SEG_A     (SEG_A),
      .SEG_B     (SEG_B),
      .SEG_C     (SEG_C),
      .SEG_D     (SEG_D),
      .SEG_E     (SEG_E),
      .SEG_F     (SEG_F),
      .SEG_G     (SEG_G),
      .CARRY_OUT (CARRY_OUT),
      .BORROW_OUT(BORROW_OUT),
      .ZERO      (ZERO)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic vec_t mkv(logic up, logic run, logic pulse, logic clr, logic load,
                                logic [3:0] ld, logic [3:0] d, logic c, logic b);
      vec_t v;
      v.up = up; v.run = run; v.pulse = pulse; v.clr = clr; v.load = load;
      v.ld = ld; v.exp_d = d; v.exp_c = c; v.exp_b = b;
      return v;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string name, input logic [3:0] d, input logic c, input logic b);
      chk({name, "_digit"}, 32'(DIGIT), 32'(d));
      chk({name, "_carry"}, 32'(CARRY_OUT), 32'(c));
      chk({name, "_borrow"}, 32'(BORROW_OUT), 32'(b));
      chk({name, "_zero"}, 32'(ZERO), 32'(d == 4'd0));
      chk({name, "_seg"}, 32'({SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G}),
          32'(seg_exp[d]));
   endtask

   // One clean carry-in pulse (4 high / 4 low) expecting an update on the 3rd edge.
   task automatic pulse_check(input string name, input logic [3:0] prev, input logic [3:0] d,
                              input logic c, input logic b);
      CARRY_IN = 1'b1;
      tick();
      tick();
      chk({name, "_latency"}, 32'(DIGIT), 32'(prev));
      tick();
      check_state(name, d, c, b);
      tick();
      chk({name, "_carry_width"}, 32'(CARRY_OUT), 32'd0);
      chk({name, "_borrow_width"}, 32'(BORROW_OUT), 32'd0);
      CARRY_IN = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      logic [3:0] prev;

      // Reset with carry held high through and after release: no step.
      RST_N = 1'b0;
      CARRY_IN = 1'b1;
      #2;
      check_state("in_reset", 4'd0, 1'b0, 1'b0);
      repeat (3) tick();
      RST_N = 1'b1;
      repeat (10) tick();
      check_state("reset_held_carry", 4'd0, 1'b0, 1'b0);
      CARRY_IN = 1'b0;
      repeat (4) tick();
      check_state("rearm_idle", 4'd0, 1'b0, 1'b0);

      // up, run, pulse, clr, load, ld, expected digit, carry, borrow
      vecs[0]  = mkv(1, 1, 1, 0, 0, 4'd0, 4'd1, 0, 0);
      vecs[1]  = mkv(1, 1, 1, 0, 0, 4'd0, 4'd2, 0, 0);
      vecs[2]  = mkv(1, 1, 1, 0, 0, 4'd0, 4'd3, 0, 0);
      vecs[3]  = mkv(1, 1, 1, 0, 0, 4'd0, 4'd4, 0, 0);
      vecs[4]  = mkv(1, 1, 1, 0, 0, 4'd0, 4'd5, 0, 0);
      vecs[5]  = mkv(1, 1, 1, 0, 0, 4'd0, 4'd0, 1, 0);
      vecs[6]  = mkv(0, 1, 1, 0, 0, 4'd0, 4'd5, 0, 1);
      vecs[7]  = mkv(0, 1, 1, 0, 0, 4'd0, 4'd4, 0, 0);
      vecs[8]  = mkv(0, 1, 1, 0, 0, 4'd0, 4'd3, 0, 0);
      vecs[9]  = mkv(0, 0, 1, 0, 0, 4'd0, 4'd3, 0, 0);
      vecs[10] = mkv(0, 0, 1, 0, 0, 4'd0, 4'd3, 0, 0);
      vecs[11] = mkv(0, 0, 1, 0, 0, 4'd0, 4'd3, 0, 0);
      vecs[12] = mkv(0, 1, 0, 0, 0, 4'd0, 4'd3, 0, 0);
      vecs[13] = mkv(1, 1, 0, 0, 1, 4'd9, 4'd5, 0, 0);

      prev = 4'd0;
      for (int i = 0; i < 14; i++) begin
         UP  = vecs[i].up;
         RUN = vecs[i].run;
         if (vecs[i].pulse) begin
            pulse_check($sformatf("vec%0d", i), prev, vecs[i].exp_d, vecs[i].exp_c, vecs[i].exp_b);
         end else begin
            CLR    = vecs[i].clr;
            LOAD   = vecs[i].load;
            LD_VAL = vecs[i].ld;
            tick();
            CLR  = 1'b0;
            LOAD = 1'b0;
            if (!vecs[i].clr && !vecs[i].load) repeat (7) tick();
            check_state($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_c, vecs[i].exp_b);
         end
         prev = vecs[i].exp_d;
      end

      // LOAD coinciding with an up-step from 5: load wins, no carry, edge discarded.
      UP = 1'b1;
      RUN = 1'b1;
      CARRY_IN = 1'b1;
      tick();
      tick();
      LOAD = 1'b1;
      LD_VAL = 4'd3;
      tick();
      LOAD = 1'b0;
      check_state("load_on_step", 4'd3, 1'b0, 1'b0);
      tick();
      check_state("load_on_step_after", 4'd3, 1'b0, 1'b0);
      CARRY_IN = 1'b0;
      repeat (4) tick();

      // CLR outranks LOAD.
      CLR = 1'b1;
      LOAD = 1'b1;
      LD_VAL = 4'd2;
      tick();
      CLR = 1'b0;
      LOAD = 1'b0;
      check_state("clr_over_load", 4'd0, 1'b0, 1'b0);

      // Move to 4, then assert reset between edges.
      LOAD = 1'b1;
      LD_VAL = 4'd4;
      tick();
      LOAD = 1'b0;
      check_state("load4", 4'd4, 1'b0, 1'b0);
      #2;
      RST_N = 1'b0;
      #1;
      check_state("mid_reset", 4'd0, 1'b0, 1'b0);
      tick();
      RST_N = 1'b1;
      repeat (4) tick();
      pulse_check("post_reset", 4'd0, 4'd1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
